// File: rtl/md_stall_ctrl.sv
// Multiply/divide unit occupancy tracker: holds the D stage on HI/LO users
// while a mult/div is in flight, and counts the stalled cycles.
module md_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_hilo_use,
  input  logic [1:0]  e_md_op,
  output logic        stall_d,
  output logic        md_issue,
  output logic        md_busy,
  output logic [1:0]  md_kind,
  output logic [3:0]  md_remaining,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_MULT = 2'd1,
    RUN_DIV  = 2'd2
  } state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic       op_mult;
  logic       op_div;

  // Reserved encoding 11 falls through both decodes and is treated as no-op.
  assign op_mult = (e_md_op == 2'b01);
  assign op_div  = (e_md_op == 2'b10);

  assign md_issue     = !reset && (state == IDLE) && (op_mult || op_div);
  assign stall_d      = !reset && d_hilo_use && (md_busy || md_issue);
  assign md_remaining = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      md_busy <= 1'b0;
      md_kind <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (op_mult) begin
            state   <= RUN_MULT;
            cnt     <= MULT_LOAD;
            md_busy <= 1'b1;
            md_kind <= 2'b01;
          end else if (op_div) begin
            state   <= RUN_DIV;
            cnt     <= DIV_LOAD;
            md_busy <= 1'b1;
            md_kind <= 2'b10;
          end
        end
        default: begin
          // Ops presented while running are ignored; the stall keeps them in E.
          if (cnt <= 4'd1) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            md_busy <= 1'b0;
            md_kind <= 2'b00;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
    end else if (stall_d && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed bench for md_stall_ctrl with hand-computed expectations.
module tb_md_stall_ctrl;

  logic        clk;
  logic        reset;
  logic        d_hilo_use;
  logic [1:0]  e_md_op;
  logic        stall_d;
  logic        md_issue;
  logic        md_busy;
  logic [1:0]  md_kind;
  logic [3:0]  md_remaining;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  md_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_hilo_use   (d_hilo_use),
    .e_md_op      (e_md_op),
    .stall_d      (stall_d),
    .md_issue     (md_issue),
    .md_busy      (md_busy),
    .md_kind      (md_kind),
    .md_remaining (md_remaining),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; d_hilo_use = 1'b1; e_md_op = 2'b01;
    next_cycle();
    #1;
    check("rst_stall_forced", 32'(stall_d), 32'd0);
    check("rst_issue_forced", 32'(md_issue), 32'd0);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_kind", 32'(md_kind), 32'd0);
    check("rst_remaining", 32'(md_remaining), 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    reset = 1'b0; d_hilo_use = 1'b0; e_md_op = 2'b00;
    next_cycle();

    // Single mult, 5 busy cycles
    e_md_op = 2'b01;
    #1;
    check("mult_issue", 32'(md_issue), 32'd1);
    next_cycle();
    e_md_op = 2'b00;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("mult_busy", 32'(md_busy), 32'd1);
      check("mult_kind", 32'(md_kind), 32'd1);
      check("mult_remaining", 32'(md_remaining), 32'(5 - k));
      check("mult_no_reissue", 32'(md_issue), 32'd0);
      next_cycle();
    end
    #1;
    check("mult_done_busy", 32'(md_busy), 32'd0);
    check("mult_done_kind", 32'(md_kind), 32'd0);
    check("mult_done_remaining", 32'(md_remaining), 32'd0);
    next_cycle();

    // Div with a HI/LO user waiting in D: 11 stalled cycles
    e_md_op = 2'b10; d_hilo_use = 1'b1;
    #1;
    check("div_stall_issue", 32'(stall_d), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      e_md_op = 2'b00;
      #1;
      check("div_stall_busy", 32'(stall_d), 32'd1);
      check("div_kind", 32'(md_kind), 32'd2);
    end
    next_cycle();
    #1;
    check("div_stall_release", 32'(stall_d), 32'd0);
    check("div_stall_count", stall_cycles, 32'd11);
    d_hilo_use = 1'b0;

    // Clear the counter, then a mult with no HI/LO user never stalls
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    e_md_op = 2'b01;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("nouse_stall", 32'(stall_d), 32'd0);
      next_cycle();
      e_md_op = 2'b00;
    end
    #1;
    check("nouse_stall_count", stall_cycles, 32'd0);

    // Reset in the middle of a div
    e_md_op = 2'b10; d_hilo_use = 1'b1;
    next_cycle();
    e_md_op = 2'b00;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    check("midrst_stall_forced", 32'(stall_d), 32'd0);
    next_cycle();
    #1;
    check("midrst_busy", 32'(md_busy), 32'd0);
    check("midrst_remaining", 32'(md_remaining), 32'd0);
    check("midrst_stall_count", stall_cycles, 32'd0);
    reset = 1'b0; d_hilo_use = 1'b0;
    next_cycle();
    #1;
    check("midrst_still_idle", 32'(md_busy), 32'd0);

    // Mult held in E: ignored while running and on the last cycle, reissues after
    e_md_op = 2'b01;
    #1;
    check("b2b_issue1", 32'(md_issue), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      #1;
      check("b2b_ignored", 32'(md_issue), 32'd0);
      check("b2b_remaining", 32'(md_remaining), 32'(6 - k));
    end
    next_cycle();
    #1;
    check("b2b_idle_gap", 32'(md_busy), 32'd0);
    check("b2b_issue2", 32'(md_issue), 32'd1);
    next_cycle();
    e_md_op = 2'b00;
    #1;
    check("b2b_reload", 32'(md_remaining), 32'd5);
    check("b2b_busy", 32'(md_busy), 32'd1);
    repeat (5) next_cycle();
    #1;
    check("b2b_drained", 32'(md_busy), 32'd0);

    // Reserved op code is a no-op
    e_md_op = 2'b11; d_hilo_use = 1'b1;
    #1;
    check("rsvd_issue", 32'(md_issue), 32'd0);
    check("rsvd_stall", 32'(stall_d), 32'd0);
    next_cycle();
    #1;
    check("rsvd_busy", 32'(md_busy), 32'd0);
    check("rsvd_kind", 32'(md_kind), 32'd0);
    e_md_op = 2'b00; d_hilo_use = 1'b0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
